// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bundle of every non-clock signal of the RV32I decode stage:
//                fetch-side valid/ready input, flush, writeback port and
//                execute-side valid/ready output with the decoded fields.
//                master : the environment (fetch, writeback, execute)
//                slave  : the decode stage itself
//  Ports       : in_valid/in_ready/in_instr/in_pc  - fetch handshake
//                flush                             - kill held + incoming
//                wb_en/wb_addr/wb_data             - register write port
//                out_valid/out_ready + out_*       - execute handshake
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_rs1_data;
  logic [DATA_W-1:0] out_rs2_data;
  logic [ADDR_W-1:0] out_rs1_addr;
  logic [ADDR_W-1:0] out_rs2_addr;
  logic [ADDR_W-1:0] out_rd_addr;
  logic [6:0]        out_opcode;
  logic [2:0]        out_funct3;
  logic [6:0]        out_funct7;
  logic [DATA_W-1:0] out_imm;

  modport master (
    output in_valid, in_instr, in_pc, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data,
           out_rs1_addr, out_rs2_addr, out_rd_addr, out_opcode, out_funct3,
           out_funct7, out_imm
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data,
           out_rs1_addr, out_rs2_addr, out_rd_addr, out_opcode, out_funct3,
           out_funct7, out_imm
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I decode stage. Holds the integer register
//                file (entry 0 hardwired to zero), decodes the instruction
//                fields and sign-extended immediate, reads both operands with
//                same-cycle writeback bypass and presents the result through
//                a valid/ready pipeline register with stall and flush.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - decode_stage_if.slave (fetch, writeback, execute)
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  localparam int c_NUM_REGS = 2 ** ADDR_W;

  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_regs [c_NUM_REGS];
  logic              w_wb_live;

  // A write to x0 is dropped everywhere: storage, bypass and refresh.
  assign w_wb_live = bus.wb_en && (bus.wb_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_live) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Field decode
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_rs1_addr;
  logic [ADDR_W-1:0] w_rs2_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [6:0]        w_opcode;

  // Size casts zero-extend or truncate the 5-bit fields to ADDR_W.
  assign w_rs1_addr = ADDR_W'(bus.in_instr[19:15]);
  assign w_rs2_addr = ADDR_W'(bus.in_instr[24:20]);
  assign w_rd_addr  = ADDR_W'(bus.in_instr[11:7]);
  assign w_opcode   = bus.in_instr[6:0];

  // --------------------------------------------------------------------------
  // Operand read with write-first bypass
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;

  always_comb begin
    w_rs1_data = '0;
    if (w_rs1_addr != '0) begin
      if (w_wb_live && (bus.wb_addr == w_rs1_addr)) begin
        w_rs1_data = bus.wb_data;
      end else begin
        w_rs1_data = r_regs[w_rs1_addr];
      end
    end
  end

  always_comb begin
    w_rs2_data = '0;
    if (w_rs2_addr != '0) begin
      if (w_wb_live && (bus.wb_addr == w_rs2_addr)) begin
        w_rs2_data = bus.wb_data;
      end else begin
        w_rs2_data = r_regs[w_rs2_addr];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Immediate generation: formed at 32 bits, then sign-extended to DATA_W
  // --------------------------------------------------------------------------
  logic signed [31:0] w_imm32;
  logic [DATA_W-1:0]  w_imm;

  always_comb begin
    w_imm32 = '0;
    case (w_opcode)
      c_OP_IMM, c_OP_LOAD, c_OP_JALR:
        w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      c_OP_STORE:
        w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      c_OP_BRANCH:
        w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                   bus.in_instr[11:8], 1'b0};
      c_OP_LUI, c_OP_AUIPC:
        w_imm32 = {bus.in_instr[31:12], 12'b0};
      c_OP_JAL:
        w_imm32 = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                   bus.in_instr[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  // Signed source, so the size cast replicates bit 31 upward.
  assign w_imm = DATA_W'(w_imm32);

  // --------------------------------------------------------------------------
  // Pipeline register
  // --------------------------------------------------------------------------
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_pc;
  logic [DATA_W-1:0] r_out_rs1_data;
  logic [DATA_W-1:0] r_out_rs2_data;
  logic [ADDR_W-1:0] r_out_rs1_addr;
  logic [ADDR_W-1:0] r_out_rs2_addr;
  logic [ADDR_W-1:0] r_out_rd_addr;
  logic [6:0]        r_out_opcode;
  logic [2:0]        r_out_funct3;
  logic [6:0]        r_out_funct7;
  logic [DATA_W-1:0] r_out_imm;

  logic w_in_ready;
  logic w_accept;

  // Depends only on the output side, so no in_valid -> in_ready path exists.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_rs1_data <= '0;
      r_out_rs2_data <= '0;
      r_out_rs1_addr <= '0;
      r_out_rs2_addr <= '0;
      r_out_rd_addr  <= '0;
      r_out_opcode   <= '0;
      r_out_funct3   <= '0;
      r_out_funct7   <= '0;
      r_out_imm      <= '0;
    end else if (bus.flush) begin
      // Held instruction is dropped (or consumed if out_ready) and the
      // incoming one is discarded; fields are left as they were.
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= bus.in_pc;
      r_out_rs1_data <= w_rs1_data;
      r_out_rs2_data <= w_rs2_data;
      r_out_rs1_addr <= w_rs1_addr;
      r_out_rs2_addr <= w_rs2_addr;
      r_out_rd_addr  <= w_rd_addr;
      r_out_opcode   <= w_opcode;
      r_out_funct3   <= bus.in_instr[14:12];
      r_out_funct7   <= bus.in_instr[31:25];
      r_out_imm      <= w_imm;
    end else if (bus.out_ready && !bus.in_valid) begin
      r_out_valid <= 1'b0;
    end else if (r_out_valid && !bus.out_ready) begin
      // A writeback landing while stalled must not leave stale operands.
      if (w_wb_live && (bus.wb_addr == r_out_rs1_addr)) begin
        r_out_rs1_data <= bus.wb_data;
      end
      if (w_wb_live && (bus.wb_addr == r_out_rs2_addr)) begin
        r_out_rs2_data <= bus.wb_data;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_rs1_data = r_out_rs1_data;
  assign bus.out_rs2_data = r_out_rs2_data;
  assign bus.out_rs1_addr = r_out_rs1_addr;
  assign bus.out_rs2_addr = r_out_rs2_addr;
  assign bus.out_rd_addr  = r_out_rd_addr;
  assign bus.out_opcode   = r_out_opcode;
  assign bus.out_funct3   = r_out_funct3;
  assign bus.out_funct7   = r_out_funct7;
  assign bus.out_imm      = r_out_imm;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered decode stage for the pipelined RV32I core. It holds the integer register file and decodes instruction fields and the sign-extended immediate. It reads both source operands with same-cycle writeback bypass and presents the result through a valid/ready pipeline register with stall and flush. It sits between fetch and execute; the writeback stage drives its write port.

## Interface
- DATA_W, 32, register and PC width; must be at least 32.
- ADDR_W, 5, register address width; the file has 2**ADDR_W entries, and entry 0 is hardwired to zero.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals !out_valid || out_ready.
- in_instr  in  32  instruction word.
- in_pc  in  DATA_W  PC of in_instr.
- flush  in  1  kill the held and incoming instruction.
- wb_en  in  1  register write enable.
- wb_addr  in  ADDR_W  write address.
- wb_data  in  DATA_W  write data.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute accepts.
- out_pc  out  DATA_W  captured PC.
- out_rs1_data, out_rs2_data  out  DATA_W  operands.
- out_rs1_addr, out_rs2_addr, out_rd_addr  out  ADDR_W  from instr[19:15], [24:20], [11:7], zero-extended or truncated to ADDR_W.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  DATA_W  sign-extended immediate.

## Operation
- Register file:
  - 2**ADDR_W x DATA_W, cleared to 0 by rst.
  - Written on a rising edge when wb_en=1 and wb_addr!=0. A write to address 0 is ignored, and reads of address 0 always return 0.
- Read bypass:
  - Combinational read data is wb_data when wb_en=1, wb_addr equals the read address, and the address is nonzero.
  - Otherwise it is the stored value.
- Immediate by opcode, all sign-extended from instr[31]:
  - I (0010011, 0000011, 1100111): instr[31:20].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode: 0.
- Pipeline register, priority per edge:
  1. rst: out_valid=0 and all out_* fields=0.
  2. flush: out_valid<=0; the incoming instruction is discarded even if in_valid && in_ready.
  3. Accept (in_valid && in_ready): load all fields from the current input and bypassed reads, out_valid<=1.
  4. Drain (out_ready && !in_valid): out_valid<=0; fields hold.
  5. Stall (out_valid && !out_ready): fields hold, except operand refresh.
- Operand refresh while stalled:
  - If wb_en=1, wb_addr!=0 and wb_addr==out_rs1_addr, then out_rs1_data<=wb_data. Same rule for rs2.
  - Both may refresh in the same edge.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 instruction per cycle when out_ready=1.
- in_ready is combinational from out_valid and out_ready; no combinational path from in_valid to in_ready.
- Writeback in the same cycle as accept is visible in the captured operands (write-first).
- After reset deassertion, the first accept can occur in the first cycle.
- rst asserted mid-stall clears out_valid immediately (asynchronously); the held instruction is lost.
- flush together with out_ready=1 and out_valid=1: the held instruction is consumed by execute this edge, and nothing new is captured.
- Regfile write and bypass use the same wb_* sample; there is no double-write hazard.

## Test plan
- Reset, then write x5=0x0000_00AA. Decode add x3,x5,x0 (0x000281B3) -> next cycle out_valid=1, out_rs1_data=0xAA, out_rs2_data=0, out_rd_addr=3, out_imm=0.
- Bypass: in the same cycle, wb x7=0x1234 and decode addi x1,x7,-1 (0xFFF38093) -> out_rs1_data=0x1234, out_imm=0xFFFF_FFFF.
- Write x0=0xDEAD, then decode an instruction reading x0 -> operand 0. Also with wb_en on x0 in the same cycle -> operand 0.
- Stall refresh: hold out_ready=0 with a held instruction reading rs2=x9. Write x9=0x55 -> out_rs2_data becomes 0x55 the next cycle. in_ready=0 throughout; fields unchanged after out_ready=1.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) -> out_imm=0xFFFF_FFFC.
  - beq x0,x0,-8 (0xFE000CE3) -> 0xFFFF_FFF8.
  - lui x1,0x12345 (0x123450B7) -> 0x1234_5000.
  - jal x1,2048 (0x001000EF) -> 0x0000_0800.
- Flush with in_valid=1 and in_ready=1 -> out_valid=0 next cycle. Assert rst during a stall -> out_valid=0 without a clock edge.
